// File: rtl/gcm_ghash_engine.sv
// Iterative GHASH/tag engine for AES-GCM: hashes AAD/ciphertext blocks with H, DIGIT_W bits per cycle.
// Optional tag comparator and i_ref_tag/o_tag_ok ports are built when GCM_TAG_VERIFY_EN is defined.
module gcm_ghash_engine #(
    parameter int DIGIT_W = 8,
    parameter int TAG_W   = 128
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [0:127]     i_h,
    input  logic [0:127]     i_encrypted_j0,
    input  logic [0:63]      i_aad_len_bits,
    input  logic [0:63]      i_ct_len_bits,
    // Block handshake: a block transfers on a rising edge where i_blk_valid and o_blk_ready
    // are both high; o_blk_ready is high only in WAIT and never depends on i_blk_valid.
    input  logic             i_blk_valid,
    output logic             o_blk_ready,
    input  logic [0:127]     i_blk,
    input  logic [4:0]       i_blk_bytes,
    input  logic             i_blk_is_aad,
    input  logic             i_blk_last,
`ifdef GCM_TAG_VERIFY_EN
    input  logic [0:TAG_W-1] i_ref_tag,
    output logic             o_tag_ok,
`endif
    output logic             o_busy,
    output logic [0:TAG_W-1] o_tag,
    output logic             o_tag_valid,
    output logic             o_seq_err,
    output logic [2:0]       o_dbg_state
);

    localparam int N     = 128 / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:127] R_POLY = 128'he1000000000000000000000000000000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_MUL   = 3'd2,
        S_LEN   = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [0:127]       h_q, h_d;
    logic [0:127]       ej0_q, ej0_d;
    logic [0:63]        aad_len_q, aad_len_d;
    logic [0:63]        ct_len_q, ct_len_d;
    logic [0:127]       y_q, y_d;
    logic [0:127]       z_q, z_d;
    logic [0:127]       v_q, v_d;
    logic [0:127]       x_q, x_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               len_done_q, len_done_d;
    logic               ct_seen_q, ct_seen_d;
    logic [0:TAG_W-1]   tag_q, tag_d;
    logic               tag_valid_q, tag_valid_d;
    logic               seq_err_q, seq_err_d;
`ifdef GCM_TAG_VERIFY_EN
    logic [0:TAG_W-1]   ref_tag_q, ref_tag_d;
    logic               tag_ok_q, tag_ok_d;
`endif

    logic [0:127]       z_step, v_step;
    logic [0:127]       blk_masked;
    logic [0:127]       y_fin;
    logic [4:0]         blk_n;
    logic               cnt_last;

    // One digit of the right-shift multiply: X is consumed MSB-first from the head of x_q.
    always_comb begin
        z_step = z_q;
        v_step = v_q;
        for (int j = 0; j < DIGIT_W; j++) begin
            if (x_q[j]) begin
                z_step = z_step ^ v_step;
            end
            if (v_step[127]) begin
                v_step = (v_step >> 1) ^ R_POLY;
            end else begin
                v_step = v_step >> 1;
            end
        end
    end

    always_comb begin
        blk_n = ((i_blk_bytes == 5'd0) || (i_blk_bytes > 5'd16)) ? 5'd16 : i_blk_bytes;
        blk_masked = i_blk;
        for (int b = 0; b < 16; b++) begin
            if (5'(b) >= blk_n) begin
                blk_masked[8*b +: 8] = 8'h00;
            end
        end
    end

    assign cnt_last = (cnt_q == CNT_W'(N - 1));
    assign y_fin    = y_q ^ ej0_q;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        ej0_d       = ej0_q;
        aad_len_d   = aad_len_q;
        ct_len_d    = ct_len_q;
        y_d         = y_q;
        z_d         = z_q;
        v_d         = v_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        len_done_d  = len_done_q;
        ct_seen_d   = ct_seen_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        seq_err_d   = seq_err_q;
`ifdef GCM_TAG_VERIFY_EN
        ref_tag_d   = ref_tag_q;
        tag_ok_d    = tag_ok_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    h_d         = i_h;
                    ej0_d       = i_encrypted_j0;
                    aad_len_d   = i_aad_len_bits;
                    ct_len_d    = i_ct_len_bits;
                    y_d         = '0;
                    last_d      = 1'b0;
                    len_done_d  = 1'b0;
                    ct_seen_d   = 1'b0;
                    tag_valid_d = 1'b0;
                    seq_err_d   = 1'b0;
`ifdef GCM_TAG_VERIFY_EN
                    ref_tag_d   = i_ref_tag;
                    tag_ok_d    = 1'b0;
`endif
                    if ((i_aad_len_bits == '0) && (i_ct_len_bits == '0)) begin
                        state_d = S_LEN;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_blk_valid) begin
                    x_d    = y_q ^ blk_masked;
                    z_d    = '0;
                    v_d    = h_q;
                    cnt_d  = '0;
                    last_d = i_blk_last;
                    if (i_blk_is_aad && ct_seen_q) begin
                        seq_err_d = 1'b1;
                    end
                    if (!i_blk_is_aad) begin
                        ct_seen_d = 1'b1;
                    end
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                z_d   = z_step;
                v_d   = v_step;
                x_d   = x_q << DIGIT_W;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    y_d   = z_step;
                    cnt_d = '0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = S_LEN;
                    end else if (len_done_q) begin
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_LEN: begin
                x_d        = y_q ^ {aad_len_q, ct_len_q};
                z_d        = '0;
                v_d        = h_q;
                cnt_d      = '0;
                len_done_d = 1'b1;
                state_d    = S_MUL;
            end
            S_FINAL: begin
                tag_d       = y_fin[0:TAG_W-1];
                tag_valid_d = 1'b1;
`ifdef GCM_TAG_VERIFY_EN
                tag_ok_d    = (y_fin[0:TAG_W-1] == ref_tag_q);
`endif
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            h_q         <= '0;
            ej0_q       <= '0;
            aad_len_q   <= '0;
            ct_len_q    <= '0;
            y_q         <= '0;
            z_q         <= '0;
            v_q         <= '0;
            x_q         <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            len_done_q  <= 1'b0;
            ct_seen_q   <= 1'b0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
`ifdef GCM_TAG_VERIFY_EN
            ref_tag_q   <= '0;
            tag_ok_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            ej0_q       <= ej0_d;
            aad_len_q   <= aad_len_d;
            ct_len_q    <= ct_len_d;
            y_q         <= y_d;
            z_q         <= z_d;
            v_q         <= v_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            len_done_q  <= len_done_d;
            ct_seen_q   <= ct_seen_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            seq_err_q   <= seq_err_d;
`ifdef GCM_TAG_VERIFY_EN
            ref_tag_q   <= ref_tag_d;
            tag_ok_q    <= tag_ok_d;
`endif
        end
    end

    assign o_blk_ready = (state_q == S_WAIT);
    assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_tag       = tag_q;
    assign o_tag_valid = tag_valid_q;
    assign o_seq_err   = seq_err_q;
    assign o_dbg_state = state_q;
`ifdef GCM_TAG_VERIFY_EN
    assign o_tag_ok    = tag_ok_q;
`endif

endmodule

// File: tb/tb_gcm_ghash_engine.sv
// Directed bench for gcm_ghash_engine: known GCM vectors, latency per digit width, masking, ordering, reset.
module tb_gcm_ghash_engine;

    localparam logic [0:127] H_K   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [0:127] EJ0_K = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [0:127] C_K   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [0:127] T2_K  = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [0:127] R_K   = 128'he1000000000000000000000000000000;
    localparam int N8 = 16;

    logic         clk;
    logic         rst_n;
    logic         start, alt_start;
    logic [0:127] h, ej0;
    logic [0:63]  aad_len, ct_len;
    logic         blk_valid, alt_valid;
    logic [0:127] blk;
    logic [4:0]   blk_bytes;
    logic         blk_is_aad, blk_last;

    logic         ready, busy, tag_valid, seq_err;
    logic [0:127] tag;
    logic [2:0]   dbg_state;

    logic         alt_ready [3];
    logic         alt_busy [3];
    logic         alt_tag_valid [3];
    logic         alt_seq_err [3];
    logic [0:127] alt_tag [3];
    logic [2:0]   alt_state [3];

`ifdef GCM_TAG_VERIFY_EN
    logic [0:127] ref_tag;
    logic         tag_ok;
    logic         alt_tag_ok [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gcm_ghash_engine #(.DIGIT_W(8), .TAG_W(128)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_h(h), .i_encrypted_j0(ej0),
        .i_aad_len_bits(aad_len), .i_ct_len_bits(ct_len),
        .i_blk_valid(blk_valid), .o_blk_ready(ready),
        .i_blk(blk), .i_blk_bytes(blk_bytes),
        .i_blk_is_aad(blk_is_aad), .i_blk_last(blk_last),
`ifdef GCM_TAG_VERIFY_EN
        .i_ref_tag(ref_tag), .o_tag_ok(tag_ok),
`endif
        .o_busy(busy), .o_tag(tag), .o_tag_valid(tag_valid),
        .o_seq_err(seq_err), .o_dbg_state(dbg_state)
    );

    for (genvar g = 0; g < 3; g++) begin : g_alt
        gcm_ghash_engine #(.DIGIT_W((g == 0) ? 1 : (g == 1) ? 32 : 128), .TAG_W(128)) alt_dut (
            .clk(clk), .i_rst_n(rst_n), .i_start(alt_start),
            .i_h(h), .i_encrypted_j0(ej0),
            .i_aad_len_bits(aad_len), .i_ct_len_bits(ct_len),
            .i_blk_valid(alt_valid), .o_blk_ready(alt_ready[g]),
            .i_blk(blk), .i_blk_bytes(blk_bytes),
            .i_blk_is_aad(blk_is_aad), .i_blk_last(blk_last),
`ifdef GCM_TAG_VERIFY_EN
            .i_ref_tag(ref_tag), .o_tag_ok(alt_tag_ok[g]),
`endif
            .o_busy(alt_busy[g]), .o_tag(alt_tag[g]), .o_tag_valid(alt_tag_valid[g]),
            .o_seq_err(alt_seq_err[g]), .o_dbg_state(alt_state[g])
        );
    end

    // Reference GF(2^128) multiply, straight from the GCM bit-serial definition.
    function automatic logic [0:127] gf_mul(input logic [0:127] x, input logic [0:127] y);
        logic [0:127] z, v;
        logic lsb;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[i]) z = z ^ v;
            lsb = v[127];
            v = v >> 1;
            if (lsb) v = v ^ R_K;
        end
        return z;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [0:63] a_len, input logic [0:63] c_len);
        aad_len = a_len;
        ct_len  = c_len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Waits (bounded) for ready, then transfers one block on the next edge.
    task automatic send_blk(input logic [0:127] data, input logic [4:0] nbytes,
                            input logic is_aad, input logic last);
        int waited;
        waited = 0;
        while (!ready && waited < 400) begin
            tick();
            waited++;
        end
        n_tests++;
        if (!ready) begin
            n_fail++;
            $display("FAIL send_blk_ready: ready=%0b after %0d cycles, required 1", ready, waited);
        end
        blk        = data;
        blk_bytes  = nbytes;
        blk_is_aad = is_aad;
        blk_last   = last;
        blk_valid  = 1'b1;
        tick();
        blk_valid  = 1'b0;
    endtask

    task automatic wait_tag(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!tag_valid && lat < 600);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_tests++; if (ready !== 1'b0)     begin n_fail++; $display("FAIL reset_ready: got %0b, required 0", ready); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        n_tests++; if (tag !== '0)         begin n_fail++; $display("FAIL reset_tag: got %h, required 0", tag); end
        n_tests++; if (tag_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tag_valid: got %0b, required 0", tag_valid); end
        n_tests++; if (seq_err !== 1'b0)   begin n_fail++; $display("FAIL reset_seq_err: got %0b, required 0", seq_err); end
    endtask

    task automatic test_zero_len();
        int lat;
        do_start(64'd0, 64'd0);
        n_tests++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL zero_busy: got %0b, required 1", busy); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready: got %0b, required 0", ready); end
        wait_tag(lat);
        n_tests++; if (lat != N8 + 2)  begin n_fail++; $display("FAIL zero_latency: got %0d, required %0d", lat, N8 + 2); end
        n_tests++; if (tag !== EJ0_K)  begin n_fail++; $display("FAIL zero_tag: got %h, required %h", tag, EJ0_K); end
    endtask

    task automatic test_digit_widths();
        int lat_main, lat_alt [3];
        int exp_alt [3];
        exp_alt[0] = 258; exp_alt[1] = 10; exp_alt[2] = 4;
        lat_main = 0;
        for (int g = 0; g < 3; g++) lat_alt[g] = 0;
        aad_len = 64'd0; ct_len = 64'd128;
        start = 1'b1; alt_start = 1'b1;
        tick();
        start = 1'b0; alt_start = 1'b0;
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL dw_ready_main: got %0b, required 1", ready); end
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if (alt_ready[g] !== 1'b1) begin n_fail++; $display("FAIL dw_ready_alt%0d: got %0b, required 1", g, alt_ready[g]); end
        end
        blk = C_K; blk_bytes = 5'd16; blk_is_aad = 1'b0; blk_last = 1'b1;
        blk_valid = 1'b1; alt_valid = 1'b1;
        tick();
        blk_valid = 1'b0; alt_valid = 1'b0;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (tag_valid && lat_main == 0) lat_main = e;
            for (int g = 0; g < 3; g++) if (alt_tag_valid[g] && lat_alt[g] == 0) lat_alt[g] = e;
        end
        n_tests++; if (lat_main != 2*N8 + 2) begin n_fail++; $display("FAIL dw8_latency: got %0d, required %0d", lat_main, 2*N8 + 2); end
        n_tests++; if (tag !== T2_K) begin n_fail++; $display("FAIL dw8_tag: got %h, required %h", tag, T2_K); end
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if (lat_alt[g] != exp_alt[g]) begin n_fail++; $display("FAIL dw_alt%0d_latency: got %0d, required %0d", g, lat_alt[g], exp_alt[g]); end
            n_tests++;
            if (alt_tag[g] !== T2_K) begin n_fail++; $display("FAIL dw_alt%0d_tag: got %h, required %h", g, alt_tag[g], T2_K); end
        end
    endtask

    task automatic test_partial_mask();
        logic [0:127] garbage, clean, exp_tag;
        int lat;
        garbage = {C_K[0:63], 64'hffffffffffffffff};
        clean   = {C_K[0:63], 64'h0};
        exp_tag = gf_mul(gf_mul(clean, H_K) ^ {64'd0, 64'd128}, H_K) ^ EJ0_K;
        do_start(64'd0, 64'd128);
        send_blk(garbage, 5'd8, 1'b0, 1'b1);
        wait_tag(lat);
        n_tests++; if (lat != 2*N8 + 2) begin n_fail++; $display("FAIL mask_latency: got %0d, required %0d", lat, 2*N8 + 2); end
        n_tests++; if (tag !== exp_tag) begin n_fail++; $display("FAIL mask_tag: got %h, required %h", tag, exp_tag); end
    endtask

    task automatic test_seq_err();
        logic [0:127] a_blk, d_blk, y, exp_tag;
        int gap, lat;
        a_blk = 128'hfeedfacedeadbeeffeedfacedeadbeef;
        d_blk = 128'h42831ec2217774244b7221b784d0d49c;
        y = gf_mul(C_K, H_K);
        y = gf_mul(y ^ a_blk, H_K);
        y = gf_mul(y ^ d_blk, H_K);
        y = gf_mul(y ^ {64'd128, 64'd256}, H_K);
        exp_tag = y ^ EJ0_K;
        do_start(64'd128, 64'd256);
        send_blk(C_K, 5'd16, 1'b0, 1'b0);
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_err_first: got %0b, required 0", seq_err); end
        gap = 0;
        while (!ready && gap < 100) begin tick(); gap++; end
        n_tests++; if (gap != N8) begin n_fail++; $display("FAIL b2b_ready_gap: got %0d, required %0d", gap, N8); end
        send_blk(a_blk, 5'd16, 1'b1, 1'b0);
        n_tests++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_err_set: got %0b, required 1", seq_err); end
        send_blk(d_blk, 5'd0, 1'b0, 1'b1);
        wait_tag(lat);
        n_tests++; if (tag !== exp_tag)  begin n_fail++; $display("FAIL seq_tag: got %h, required %h", tag, exp_tag); end
        n_tests++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_err_held: got %0b, required 1", seq_err); end
        do_start(64'd0, 64'd0);
        n_tests++; if (seq_err !== 1'b0)   begin n_fail++; $display("FAIL seq_err_clear: got %0b, required 0", seq_err); end
        n_tests++; if (tag_valid !== 1'b0) begin n_fail++; $display("FAIL restart_tag_valid: got %0b, required 0", tag_valid); end
        wait_tag(lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        do_start(64'd0, 64'd256);
        send_blk(C_K, 5'd16, 1'b0, 1'b0);
        send_blk(C_K, 5'd16, 1'b0, 1'b1);
        tick(); tick(); tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %0b, required 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++; if (ready !== 1'b0)     begin n_fail++; $display("FAIL mid_reset_ready: got %0b, required 0", ready); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_reset_busy: got %0b, required 0", busy); end
        n_tests++; if (tag !== '0)         begin n_fail++; $display("FAIL mid_reset_tag: got %h, required 0", tag); end
        n_tests++; if (tag_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tag_valid: got %0b, required 0", tag_valid); end
        do_start(64'd0, 64'd128);
        send_blk(C_K, 5'd16, 1'b0, 1'b1);
        wait_tag(lat);
        n_tests++; if (tag !== T2_K) begin n_fail++; $display("FAIL mid_fresh_tag: got %h, required %h", tag, T2_K); end
    endtask

`ifdef GCM_TAG_VERIFY_EN
    task automatic test_tag_verify();
        int lat;
        logic [0:127] bad;
        ref_tag = T2_K;
        do_start(64'd0, 64'd128);
        send_blk(C_K, 5'd16, 1'b0, 1'b1);
        wait_tag(lat);
        n_tests++; if (tag_ok !== 1'b1) begin n_fail++; $display("FAIL verify_ok: got %0b, required 1", tag_ok); end
        bad = T2_K;
        bad[127] = ~bad[127];
        ref_tag = bad;
        do_start(64'd0, 64'd128);
        send_blk(C_K, 5'd16, 1'b0, 1'b1);
        wait_tag(lat);
        n_tests++; if (tag_ok !== 1'b0) begin n_fail++; $display("FAIL verify_bad: got %0b, required 0", tag_ok); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; alt_start = 1'b0;
        h = H_K; ej0 = EJ0_K; aad_len = '0; ct_len = '0;
        blk_valid = 1'b0; alt_valid = 1'b0; blk = '0; blk_bytes = 5'd16;
        blk_is_aad = 1'b0; blk_last = 1'b0;
`ifdef GCM_TAG_VERIFY_EN
        ref_tag = '0;
`endif
        test_reset();
        test_zero_len();
        test_digit_widths();
        test_partial_mask();
        test_seq_err();
        test_reset_mid();
`ifdef GCM_TAG_VERIFY_EN
        test_tag_verify();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
